// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// waits on memory with a bounded timeout, and keeps a sticky trap plus a retired count.
module multicycle_ctrl #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic [5:0]          funct_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic [1:0]          pc_src_o,
  output logic                ir_write_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [1:0]          alu_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          wb_sel_o,
  output logic [2:0]          state_o,
  output logic                trap_o,
  output logic [COUNT_W-1:0]  retired_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [5:0]          op_q, op_d, funct_q, funct_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [COUNT_W-1:0]  retired_q, retired_d;
  logic                timeout_hit;
  logic [3:0]          alu4;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL, OP_ADDI,
      OP_SLTIU, OP_BEQ, OP_LUI, OP_ORI, OP_BNE: is_supported = 1'b1;
      default:                                  is_supported = 1'b0;
    endcase
  endfunction

  // Handshake: the memory request (mem_read_o/mem_write_o) is held every cycle of
  // FETCH/MEM; mem_ready_i high in a cycle completes it at that cycle's rising edge.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i)      state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
        else if (MEM_TIMEOUT != 0) wait_d = wait_q + WAIT_W'(1);
      end
      S_DECODE: begin
        op_d    = instr_op_i;
        funct_d = funct_i;
        if (instr_op_i == OP_J)                             state_d = S_FETCH;
        else if (instr_op_i == OP_JAL)                      state_d = S_WB;
        else if (instr_op_i == OP_R && funct_i == FN_JR)    state_d = S_FETCH;
        else if (is_supported(instr_op_i))                  state_d = S_EXEC;
        else                                                state_d = S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_FETCH;
          OP_LW, OP_SW:                     state_d = S_MEM;
          default:                          state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i)      state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_TRAP;
        else if (MEM_TIMEOUT != 0) wait_d = wait_q + WAIT_W'(1);
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // Any state change restarts the wait count, so each FETCH/MEM entry begins at 0.
    if (state_d != state_q) wait_d = '0;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
      retired_d = retired_q + COUNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are gated by rst_i so every control drops the instant reset asserts.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'd0;
    ir_write_o      = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    alu_src_o       = 2'd0;
    alu4            = 4'd0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 2'd0;
    wb_sel_o        = 2'd0;
    trap_o          = 1'b0;
    if (rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o = 1'b1;
          ir_write_o = mem_ready_i;
          pc_write_o = mem_ready_i;
        end
        S_DECODE: begin
          if (instr_op_i == OP_J || instr_op_i == OP_JAL) begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'd2;
          end else if (instr_op_i == OP_R && funct_i == FN_JR) begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'd3;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R:     alu4 = 4'b0010;
            OP_LW:    begin alu4 = 4'b1000; alu_src_o = 2'd1; end
            OP_SW:    begin alu4 = 4'b1001; alu_src_o = 2'd1; end
            OP_BLEZ:  alu4 = 4'b1010;
            OP_BGTZ:  alu4 = 4'b1011;
            OP_ADDI:  begin alu4 = 4'b0100; alu_src_o = 2'd1; end
            OP_SLTIU: begin alu4 = 4'b0110; alu_src_o = 2'd2; end
            OP_BEQ:   alu4 = 4'b0001;
            OP_LUI:   alu4 = 4'b0111;
            OP_ORI:   begin alu4 = 4'b0101; alu_src_o = 2'd2; end
            OP_BNE:   alu4 = 4'b0011;
            default:  alu4 = 4'b0000;
          endcase
          if (op_q == OP_BEQ || op_q == OP_BNE || op_q == OP_BLEZ || op_q == OP_BGTZ) begin
            pc_write_cond_o = 1'b1;
            pc_src_o        = 2'd1;
          end
        end
        S_MEM: begin
          i_or_d_o    = 1'b1;
          mem_read_o  = (op_q == OP_LW);
          mem_write_o = (op_q == OP_SW);
        end
        S_WB: begin
          reg_write_o = 1'b1;
          case (op_q)
            OP_R:    reg_dst_o = 2'd1;
            OP_LW:   wb_sel_o  = 2'd1;
            OP_JAL:  begin reg_dst_o = 2'd2; wb_sel_o = 2'd2; end
            default: begin reg_dst_o = 2'd0; wb_sel_o = 2'd0; end
          endcase
        end
        S_TRAP:  trap_o = 1'b1;
        default: trap_o = 1'b0;
      endcase
    end
    alu_op_o = ALU_OP_W'(alu4);
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and packed control vectors
// are compared against hand-built expectations; MEM_TIMEOUT is 4 in this instance.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  instr_op_i;
  logic [5:0]  funct_i;
  logic        mem_ready_i;
  logic        pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o;
  logic        mem_read_o, mem_write_o, reg_write_o, trap_o;
  logic [1:0]  pc_src_o, alu_src_o, reg_dst_o, wb_sel_o;
  logic [3:0]  alu_op_o;
  logic [2:0]  state_o;
  logic [31:0] retired_o;
  logic [19:0] ctrl;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_ret;

  multicycle_ctrl #(.ALU_OP_W(4), .MEM_TIMEOUT(4), .COUNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .pc_src_o(pc_src_o), .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .alu_src_o(alu_src_o),
    .alu_op_o(alu_op_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .wb_sel_o(wb_sel_o), .state_o(state_o), .trap_o(trap_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  assign ctrl = {pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, i_or_d_o, mem_read_o,
                 mem_write_o, alu_src_o, alu_op_o, reg_write_o, reg_dst_o, wb_sel_o, trap_o};

  // Field order: pcw pcwc psrc irw iord mr mw asrc aop rw rdst wsel trap
  function automatic logic [19:0] cv(input int pcw, input int pcwc, input int psrc,
                                     input int irw, input int iord, input int mr,
                                     input int mw, input int asrc, input int aop,
                                     input int rw, input int rdst, input int wsel,
                                     input int trp);
    return {1'(pcw), 1'(pcwc), 2'(psrc), 1'(irw), 1'(iord), 1'(mr), 1'(mw),
            2'(asrc), 4'(aop), 1'(rw), 2'(rdst), 2'(wsel), 1'(trp)};
  endfunction

  logic [19:0] f_rdy, f_wait, trap_c;

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    @(negedge clk_i);
    instr_op_i  = op;
    funct_i     = fn;
    mem_ready_i = rdy;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; instr_op_i = 6'd0; funct_i = 6'd0; mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      n_cmp++;
      if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
      n_cmp++;
      if (ctrl !== 20'd0) begin n_err++; $display("FAIL reset_ctrl: got %h want 00000", ctrl); end
      n_cmp++;
      if (retired_o !== 32'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired_o); end
    end
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (ctrl !== f_wait) begin n_err++; $display("FAIL reset_release_ctrl: got %h want %h", ctrl, f_wait); end
    exp_ret = 0;
  endtask

  task automatic test_add();
    logic [2:0]  es[5];
    logic [19:0] ec[5];
    logic        rd[5];
    es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ec = '{f_rdy, 20'd0, cv(0,0,0,0,0,0,0,0,2,0,0,0,0), cv(0,0,0,0,0,0,0,0,0,1,1,0,0), f_wait};
    for (int i = 0; i < 5; i++) begin
      drive(6'b000000, 6'b100000, rd[i]);
      n_cmp++;
      if (state_o !== es[i]) begin n_err++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
      n_cmp++;
      if (ctrl !== ec[i]) begin n_err++; $display("FAIL add_ctrl[%0d]: got %h want %h", i, ctrl, ec[i]); end
    end
    exp_ret = exp_ret + 1;
    n_cmp++;
    if (retired_o !== exp_ret) begin n_err++; $display("FAIL add_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_lw();
    logic [2:0]  es[9];
    logic [19:0] ec[9];
    logic        rd[9];
    logic [19:0] mem_c;
    mem_c = cv(0,0,0,0,1,1,0,0,0,0,0,0,0);
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ec = '{f_rdy, 20'd0, cv(0,0,0,0,0,0,0,1,8,0,0,0,0), mem_c, mem_c, mem_c, mem_c,
           cv(0,0,0,0,0,0,0,0,0,1,0,1,0), f_wait};
    for (int i = 0; i < 9; i++) begin
      drive(6'b100011, 6'd0, rd[i]);
      n_cmp++;
      if (state_o !== es[i]) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
      n_cmp++;
      if (ctrl !== ec[i]) begin n_err++; $display("FAIL lw_ctrl[%0d]: got %h want %h", i, ctrl, ec[i]); end
    end
    exp_ret = exp_ret + 1;
    n_cmp++;
    if (retired_o !== exp_ret) begin n_err++; $display("FAIL lw_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  op[9];
    logic [5:0]  fn[9];
    logic [2:0]  es[9];
    logic [19:0] ec[9];
    logic        rd[9];
    op = '{6'b000100, 6'b000100, 6'b000100, 6'b000011, 6'b000011, 6'b000011,
           6'b000000, 6'b000000, 6'b000000};
    fn = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b001000, 6'b001000, 6'b001000};
    rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    es = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd0};
    ec = '{f_rdy, 20'd0, cv(0,1,1,0,0,0,0,0,1,0,0,0,0),
           f_rdy, cv(1,0,2,0,0,0,0,0,0,0,0,0,0), cv(0,0,0,0,0,0,0,0,0,1,2,2,0),
           f_rdy, cv(1,0,3,0,0,0,0,0,0,0,0,0,0), f_wait};
    for (int i = 0; i < 9; i++) begin
      drive(op[i], fn[i], rd[i]);
      n_cmp++;
      if (state_o !== es[i]) begin n_err++; $display("FAIL bj_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
      n_cmp++;
      if (ctrl !== ec[i]) begin n_err++; $display("FAIL bj_ctrl[%0d]: got %h want %h", i, ctrl, ec[i]); end
    end
    exp_ret = exp_ret + 3;
    n_cmp++;
    if (retired_o !== exp_ret) begin n_err++; $display("FAIL bj_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_itype();
    logic [5:0]  op[9];
    logic [2:0]  es[9];
    logic [19:0] ec[9];
    logic        rd[9];
    logic [19:0] wb_i;
    wb_i = cv(0,0,0,0,0,0,0,0,0,1,0,0,0);
    op = '{6'b001101, 6'b001101, 6'b001101, 6'b001101,
           6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b001111};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    ec = '{f_rdy, 20'd0, cv(0,0,0,0,0,0,0,2,5,0,0,0,0), wb_i,
           f_rdy, 20'd0, cv(0,0,0,0,0,0,0,0,7,0,0,0,0), wb_i, f_wait};
    for (int i = 0; i < 9; i++) begin
      drive(op[i], 6'd0, rd[i]);
      n_cmp++;
      if (state_o !== es[i]) begin n_err++; $display("FAIL itype_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
      n_cmp++;
      if (ctrl !== ec[i]) begin n_err++; $display("FAIL itype_ctrl[%0d]: got %h want %h", i, ctrl, ec[i]); end
    end
    exp_ret = exp_ret + 2;
    n_cmp++;
    if (retired_o !== exp_ret) begin n_err++; $display("FAIL itype_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_bad_opcode();
    logic [2:0]  es[4];
    logic [19:0] ec[4];
    logic        rd[4];
    es = '{3'd0, 3'd1, 3'd7, 3'd7};
    rd = '{1'b1, 1'b0, 1'b1, 1'b1};
    ec = '{f_rdy, 20'd0, trap_c, trap_c};
    for (int i = 0; i < 4; i++) begin
      drive(6'b111111, 6'd0, rd[i]);
      n_cmp++;
      if (state_o !== es[i]) begin n_err++; $display("FAIL badop_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
      n_cmp++;
      if (ctrl !== ec[i]) begin n_err++; $display("FAIL badop_ctrl[%0d]: got %h want %h", i, ctrl, ec[i]); end
    end
    n_cmp++;
    if (retired_o !== exp_ret) begin n_err++; $display("FAIL badop_retired: got %0d want %0d", retired_o, exp_ret); end
  endtask

  task automatic test_timeout();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b0; instr_op_i = 6'd0; funct_i = 6'd0;
    exp_ret = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(6'd0, 6'd0, 1'b0);
      n_cmp++;
      if (state_o !== 3'd0) begin n_err++; $display("FAIL to_wait_state[%0d]: got %0d want 0", i, state_o); end
      n_cmp++;
      if (ctrl !== f_wait) begin n_err++; $display("FAIL to_wait_ctrl[%0d]: got %h want %h", i, ctrl, f_wait); end
    end
    for (int i = 0; i < 21; i++) begin
      drive(6'd0, 6'd0, (i == 0) ? 1'b0 : 1'b1);
      n_cmp++;
      if (state_o !== 3'd7) begin n_err++; $display("FAIL to_trap_state[%0d]: got %0d want 7", i, state_o); end
      n_cmp++;
      if (ctrl !== trap_c) begin n_err++; $display("FAIL to_trap_ctrl[%0d]: got %h want %h", i, ctrl, trap_c); end
    end
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (trap_o !== 1'b0 || ctrl !== 20'd0) begin n_err++; $display("FAIL to_clear: got %h want 00000", ctrl); end
    n_cmp++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL to_clear_state: got %0d want 0", state_o); end
    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_sw();
    logic [2:0]  es[4];
    logic [19:0] ec[4];
    logic        rd[4];
    es = '{3'd0, 3'd1, 3'd2, 3'd3};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0};
    ec = '{f_rdy, 20'd0, cv(0,0,0,0,0,0,0,1,9,0,0,0,0), cv(0,0,0,0,1,0,1,0,0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      drive(6'b101011, 6'd0, rd[i]);
      n_cmp++;
      if (state_o !== es[i]) begin n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_o, es[i]); end
      n_cmp++;
      if (ctrl !== ec[i]) begin n_err++; $display("FAIL sw_ctrl[%0d]: got %h want %h", i, ctrl, ec[i]); end
    end
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (ctrl !== 20'd0) begin n_err++; $display("FAIL sw_async_ctrl: got %h want 00000", ctrl); end
    n_cmp++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL sw_async_state: got %0d want 0", state_o); end
    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(6'b101011, 6'd0, 1'b0);
      n_cmp++;
      if (state_o !== 3'd0) begin n_err++; $display("FAIL sw_after_state[%0d]: got %0d want 0", i, state_o); end
      n_cmp++;
      if (ctrl !== f_wait) begin n_err++; $display("FAIL sw_after_ctrl[%0d]: got %h want %h", i, ctrl, f_wait); end
      n_cmp++;
      if (retired_o !== 32'd0) begin n_err++; $display("FAIL sw_after_retired[%0d]: got %0d want 0", i, retired_o); end
    end
  endtask

  initial begin
    f_rdy  = cv(1,0,0,1,0,1,0,0,0,0,0,0,0);
    f_wait = cv(0,0,0,0,0,1,0,0,0,0,0,0,0);
    trap_c = cv(0,0,0,0,0,0,0,0,0,0,0,0,1);
    exp_ret = 0;
    test_reset();
    test_add();
    test_lw();
    test_branch_jump();
    test_itype();
    test_bad_opcode();
    apply_reset();
    test_timeout();
    test_reset_mid_sw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the MIPS-subset CPU. It replaces the single-cycle opcode decoder with a state machine that sequences FETCH, DECODE, EXEC, MEM and WB.
- It supports variable-latency memory through a ready handshake and a wait timeout. It also adds jr/jal link handling, a sticky trap and a retired-instruction counter.
- Sits between the instruction register and the shared datapath: PC, IR, regfile, ALU and unified memory.

Parameters:
- ALU_OP_W, 4: width of alu_op_o; the 4-bit op codes are zero-extended to this width.
- MEM_TIMEOUT, 16: maximum wait cycles in FETCH/MEM before a trap; 0 disables the timeout.
- COUNT_W, 32: width of retired_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- instr_op_i  in  6  opcode from the IR.
- funct_i  in  6  funct field from the IR.
- mem_ready_i  in  1  memory completes this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load if the datapath branch condition is true.
- pc_src_o  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- ir_write_o  out  1  IR load.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- alu_src_o  out  2  ALU B source: 0 = rt, 1 = sign-extended immediate, 2 = zero-extended immediate.
- alu_op_o  out  ALU_OP_W  ALU operation code.
- reg_write_o  out  1  register-file write enable.
- reg_dst_o  out  2  destination register: 0 = rt, 1 = rd, 2 = r31.
- wb_sel_o  out  2  write-back source: 0 = ALU result, 1 = memory data, 2 = link (PC+4 latched by the datapath during FETCH).
- state_o  out  3  current state; FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- trap_o  out  1  sticky error flag.
- retired_o  out  COUNT_W  count of retired instructions.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to FETCH; op_q, funct_q, wait counter and retired_o clear to 0.
  - While rst_i is low, every control output is forced to 0 and trap_o is 0.
  - Reset asserted mid-instruction abandons the instruction; it is not counted.
- Control outputs are combinational from state, op_q/funct_q and mem_ready_i. Any output not listed for a state is 0.
- FETCH:
  - mem_read_o=1, i_or_d_o=0.
  - ir_write_o and pc_write_o equal mem_ready_i, with pc_src_o=0.
  - mem_ready_i=1 goes to DECODE; otherwise stay and increment the wait counter.
- DECODE (1 cycle): latch op_q=instr_op_i and funct_q=funct_i, then branch on the opcode:
  - j (000010): pc_write_o=1, pc_src_o=2, go to FETCH.
  - jal (000011): pc_write_o=1, pc_src_o=2, go to WB.
  - R-type with funct 001000 (jr): pc_write_o=1, pc_src_o=3, go to FETCH.
  - Other supported opcodes go to EXEC.
  - Unsupported opcodes go to TRAP.
- Supported opcodes: 000000, 100011, 101011, 000110, 000111, 000010, 000011, 001000, 001011, 000100, 001111, 001101, 000101.
- EXEC:
  - alu_op_o by opcode: R 0010, lw 1000, sw 1001, blez 1010, bgtz 1011, addi 0100, sltiu 0110, beq 0001, lui 0111, ori 0101, bne 0011.
  - alu_src_o: 1 for lw, sw and addi; 2 for sltiu and ori; 0 otherwise (including lui).
  - Branches (beq, bne, blez, bgtz): pc_write_cond_o=1, pc_src_o=1, go to FETCH.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - i_or_d_o=1; mem_read_o=1 for lw, mem_write_o=1 for sw.
  - Hold until mem_ready_i=1, then lw goes to WB and sw goes to FETCH.
- WB (1 cycle): reg_write_o=1, then go to FETCH.
  - R-type: reg_dst 1, wb_sel 0.
  - lw: reg_dst 0, wb_sel 1.
  - I-type ALU: reg_dst 0, wb_sel 0.
  - jal: reg_dst 2, wb_sel 2.
- Wait counter:
  - Resets to 0 on every entry to FETCH or MEM.
  - If MEM_TIMEOUT≠0 and MEM_TIMEOUT consecutive cycles pass with mem_ready_i=0, go to TRAP on the next edge.
  - mem_ready_i arriving in the last allowed cycle completes normally.
- TRAP: terminal state with trap_o=1 and all other controls 0. Only reset exits it.
- retired_o:
  - Increments by 1 on each transition into FETCH from DECODE, EXEC, MEM or WB.
  - Wraps modulo 2^COUNT_W.
  - Never increments on entry to or while in TRAP.

Test Plan:
- Reset, then release; hold mem_ready_i=1 and run add (op 000000, funct 100000). Required: states 0,1,2,4,0; alu_op_o=0010 in EXEC; reg_write_o=1 with reg_dst_o=1 in WB; retired_o=1.
- lw with mem_ready_i low for 3 MEM cycles. Required: MEM held 4 cycles with mem_read_o=1, i_or_d_o=1; then WB with wb_sel_o=1; total 8 cycles.
- beq, then jal, then jr (funct 001000). Required:
  - beq: pc_write_cond_o=1, pc_src_o=1 in EXEC, then FETCH.
  - jal: DECODE has pc_src_o=2, then WB with reg_dst_o=2, wb_sel_o=2.
  - jr: pc_src_o=3 in DECODE, then FETCH.
  - retired_o=3.
- MEM_TIMEOUT=4, FETCH with mem_ready_i held 0. Required: TRAP (state 7) after 4 wait cycles; trap_o stays 1 for 20 further cycles; only rst_i low clears it.
- Opcode 111111 in DECODE. Required: next state TRAP, all controls 0, retired_o unchanged.
- Assert rst_i low mid-MEM of sw. Required: outputs 0 immediately (asynchronously); after release state 0, retired_o=0, no mem_write_o pulse.
